// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: stall/bubble generation, exception drain/freeze FSM.
// Optional performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_destM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [1:0]       m_status,
  input  logic [1:0]       W_status,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             halted,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] luse_cnt,
  output logic [CNT_W-1:0] mispred_cnt,
  output logic [CNT_W-1:0] ret_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } state_t;

  localparam logic [3:0] IC_JXX    = 4'h7;
  localparam logic [3:0] IC_RET    = 4'h9;
  localparam logic [3:0] IC_MRMOVQ = 4'h5;
  localparam logic [3:0] IC_POPQ   = 4'hB;
  localparam logic [3:0] REG_NONE  = 4'hF;

  state_t r_state;
  state_t w_next;
  logic   r_halted;

  logic w_luse;
  logic w_mispred;
  logic w_ret_h;
  logic w_m_exc;
  logic w_w_exc;

  // Status 01 (HLT) and 10 (ADR/INS) are exceptional; 00 and 11 are not.
  assign w_luse    = ((E_icode == IC_MRMOVQ) || (E_icode == IC_POPQ)) &&
                     (E_destM != REG_NONE) &&
                     ((E_destM == d_srcA) || (E_destM == d_srcB));
  assign w_mispred = (E_icode == IC_JXX) && !e_Cnd;
  assign w_ret_h   = (D_icode == IC_RET) || (E_icode == IC_RET) || (M_icode == IC_RET);
  assign w_m_exc   = m_status[0] ^ m_status[1];
  assign w_w_exc   = W_status[0] ^ W_status[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= RUN;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_halted <= (w_next == HALTED);
    end
  end

  always_comb begin
    w_next   = r_state;
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    W_stall  = 1'b0;
    case (r_state)
      RUN: begin
        // A load/use stall wins over a ret bubble in D; mispredict bubbles D regardless.
        F_stall  = w_luse | w_ret_h;
        D_stall  = w_luse;
        D_bubble = w_mispred | (w_ret_h & !w_luse);
        E_bubble = w_mispred | w_luse;
        M_bubble = w_m_exc | w_w_exc;
        W_stall  = w_w_exc;
        if (w_w_exc)      w_next = HALTED;
        else if (w_m_exc) w_next = DRAIN;
      end
      DRAIN: begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
        W_stall  = w_w_exc;
        if (w_w_exc) w_next = HALTED;
      end
      HALTED: begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
        W_stall  = 1'b1;
      end
      default: w_next = RUN;
    endcase
    // Holding reset flushes D/E/M and lets nothing stall, whatever the state.
    if (!rst_n) begin
      F_stall  = 1'b0;
      D_stall  = 1'b0;
      D_bubble = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
      W_stall  = 1'b0;
    end
  end

  assign halted    = r_halted;
  assign dbg_state = r_state;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] r_cyc_cnt;
  logic [CNT_W-1:0] r_luse_cnt;
  logic [CNT_W-1:0] r_mispred_cnt;
  logic [CNT_W-1:0] r_ret_cnt;
  logic             w_cnt_en;

  assign w_cnt_en = (r_state != HALTED);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? (v + CNT_W'(1)) : v;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cyc_cnt     <= '0;
      r_luse_cnt    <= '0;
      r_mispred_cnt <= '0;
      r_ret_cnt     <= '0;
    end else begin
      r_cyc_cnt     <= sat_inc(r_cyc_cnt,     w_cnt_en);
      r_luse_cnt    <= sat_inc(r_luse_cnt,    w_cnt_en & w_luse);
      r_mispred_cnt <= sat_inc(r_mispred_cnt, w_cnt_en & w_mispred);
      r_ret_cnt     <= sat_inc(r_ret_cnt,     w_cnt_en & w_ret_h & !w_luse);
    end
  end

  assign cyc_cnt     = r_cyc_cnt;
  assign luse_cnt    = r_luse_cnt;
  assign mispred_cnt = r_mispred_cnt;
  assign ret_cnt     = r_ret_cnt;
`else
  assign cyc_cnt     = '0;
  assign luse_cnt    = '0;
  assign mispred_cnt = '0;
  assign ret_cnt     = '0;
`endif

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage Y86-64 pipeline. Observes the decode, execute, memory and write-back stages and produces the stall and bubble controls for the F, D, E, M and W pipeline registers. It resolves load/use hazards, branch mispredicts and `ret` hazards. A small state machine drains the pipeline and freezes it once an exceptional status reaches write-back. Optional performance counters are included.

## Interface
Parameters:
- `CNT_W`, default 32: width of each performance counter.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `D_icode` in 4: icode held in the decode register.
- `d_srcA`, `d_srcB` in 4 each: decode-stage source register IDs; 4'hF means none.
- `E_icode` in 4: icode held in the execute register.
- `E_destM` in 4: execute-register memory destination; 4'hF means none.
- `e_Cnd` in 1: branch condition computed in execute.
- `M_icode` in 4: icode held in the memory register.
- `m_status` in 2: status leaving the memory stage.
- `W_status` in 2: status held in the write-back register.
- `F_stall`, `D_stall`, `D_bubble`, `E_bubble`, `M_bubble`, `W_stall` out 1 each: pipeline register controls.
- `halted` out 1: registered; the pipeline is frozen.
- `cyc_cnt`, `luse_cnt`, `mispred_cnt`, `ret_cnt` out `CNT_W` each: performance counters.

## Operation
- Status codes:
  - 2'b00 = AOK
  - 2'b01 = HLT
  - 2'b10 = ADR/INS error
  - 2'b11 = bubble (non-exceptional)
  - A status is exceptional when it is 01 or 10.
- Icodes used:
  - 0 = HALT, 7 = JXX, 9 = RET, 5 = MRMOVQ, B = POPQ.
- Hazard terms (combinational):
  - `luse` = (E_icode==5 or E_icode==B) and E_destM!=F and (E_destM==d_srcA or E_destM==d_srcB).
  - `mispred` = E_icode==7 and !e_Cnd.
  - `ret_h` = RET in any of D_icode, E_icode, M_icode.
  - `m_exc` = m_status exceptional.
  - `w_exc` = W_status exceptional.
- FSM state encoding: RUN=2'b00, DRAIN=2'b01, HALTED=2'b10.
- Outputs in RUN:
  - F_stall = luse | ret_h
  - D_stall = luse
  - D_bubble = mispred | (ret_h & !luse)
  - E_bubble = mispred | luse
  - M_bubble = m_exc | w_exc
  - W_stall = w_exc
- Outputs in DRAIN:
  - F_stall=1, D_stall=1, E_bubble=1, M_bubble=1, D_bubble=0.
  - W_stall = w_exc.
- Outputs in HALTED:
  - F_stall=1, D_stall=1, E_bubble=1, M_bubble=1, W_stall=1, D_bubble=0.
- Transitions:
  - RUN→DRAIN on m_exc & !w_exc.
  - RUN→HALTED on w_exc.
  - DRAIN→HALTED on w_exc.
  - DRAIN stays DRAIN otherwise.
  - HALTED is sticky; only reset leaves it.
- `halted` = (state==HALTED), registered.
- Priority:
  - luse with ret_h: D_stall=1, D_bubble=0.
  - mispred with ret_h: D_bubble=1.
  - mispred with luse cannot occur (JXX has no destM); no special handling.

## Timing
- All stall and bubble outputs are combinational from current inputs and current state, valid in the same cycle.
- State, `halted` and the counters update on the rising edge of `clk`.
- Reset:
  - With rst_n==0 sampled at an edge: state←RUN, halted←0, all counters←0.
  - While rst_n==0: D_bubble=E_bubble=M_bubble=1 and F_stall=D_stall=W_stall=0, independent of state.
- Reset mid-operation (in DRAIN or HALTED) returns to RUN on the next edge with counters cleared.
- A load/use stall lasts exactly 1 cycle for a single hazard.
- A mispredict costs 2 bubbles (D and E in one cycle).
- A `ret` holds F for 3 cycles (ret in D, then E, then M).
- `halted` rises 1 cycle after the first cycle in which W_status is exceptional.

## Configuration
- `PIPE_CTRL_PERF_EN`, defined:
  - Counters are active and saturate at all-ones.
  - All counters hold in HALTED and while rst_n==0.
  - `cyc_cnt` increments every RUN/DRAIN cycle.
  - `luse_cnt` increments on each cycle with luse.
  - `mispred_cnt` increments on each cycle with mispred.
  - `ret_cnt` increments on each cycle with ret_h & !luse.
- `PIPE_CTRL_PERF_EN`, undefined:
  - No counter registers are built; all four counter outputs are constant 0.
  - Hazard control is identical to the defined case.

## Test plan
- Load/use: E_icode=5, E_destM=3, d_srcA=3 → F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; the next cycle, with E_icode=1, all controls are 0; luse_cnt=1.
- Mispredict: E_icode=7, e_Cnd=0 → D_bubble=1, E_bubble=1, F_stall=0; with e_Cnd=1 all controls are 0.
- Ret: RET in D for 1 cycle, then E, then M → F_stall=1 and D_bubble=1 for 3 cycles; with luse raised in the second cycle, D_stall=1 and D_bubble=0 in that cycle.
- Exception drain: m_status=10 for 1 cycle, then W_status=10 → M_bubble=1 and state DRAIN; the next cycle W_stall=1; halted=1 one cycle later; all stall outputs stay asserted for 10 further cycles.
- Reset from HALTED: rst_n=0 for 1 edge → halted=0, counters 0; while low, D/E/M_bubble=1; after release, normal hazard response resumes.
- Saturation (CNT_W=4, macro defined): 20 RUN cycles → cyc_cnt=4'hF and held; with the macro undefined, all counters read 0.
